// File: rtl/store_buffer_pkg.sv
// Shared widths, buffer entry type and the STORE_BUFFER_FORWARD_EN build switch
// (defined: loads that hit the buffer are forwarded; undefined: they stall until drained).
package store_buffer_pkg;

  localparam int unsigned SbWord     = 32;
  localparam int unsigned SbAddressL = 32;

  typedef struct packed {
    logic [SbAddressL-1:0] addr;
    logic [SbWord-1:0]     data;
  } sb_entry_t;

`ifdef STORE_BUFFER_FORWARD_EN
  localparam bit SbForwardEn = 1'b1;
`else
  localparam bit SbForwardEn = 1'b0;
`endif

endpackage

// File: rtl/store_buffer_if.sv
// Data-memory port: the store buffer is the master, the memory is the slave.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int unsigned WORD     = SbWord,
  parameter int unsigned ADDRESSL = SbAddressL
);

  logic [ADDRESSL-1:0] memAddress;
  logic [WORD-1:0]     memWriteData;
  logic                memRead;
  logic                memWrite;
  logic [WORD-1:0]     memReadData;

  modport master (
    output memAddress,
    output memWriteData,
    output memRead,
    output memWrite,
    input  memReadData
  );

  modport slave (
    input  memAddress,
    input  memWriteData,
    input  memRead,
    input  memWrite,
    output memReadData
  );

endinterface

// File: rtl/sb_match.sv
// Address compare across all valid buffer entries; when forwarding is built in, also selects
// the data of the youngest matching entry (the one closest to the tail).
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTRW  = $clog2(DEPTH)
) (
  input  sb_entry_t             entries_i [DEPTH],
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [PTRW-1:0]       head_i,
  input  logic [SbAddressL-1:0] req_address_i,
  output logic                  hit_o,
  output logic [SbWord-1:0]     data_o
);

  logic [DEPTH-1:0] match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = valid_i[i] && (entries_i[i].addr == req_address_i);
  end

  assign hit_o = |match;

  if (SbForwardEn) begin : g_fwd
    logic [PTRW-1:0] idx;

    // Walk oldest to youngest so the last hit seen wins.
    always_comb begin
      data_o = '0;
      idx    = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        idx = PTRW'(head_i + PTRW'(k));
        if (match[idx]) begin
          data_o = entries_i[idx].data;
        end
      end
    end
  end else begin : g_no_fwd
    logic [DEPTH-1:0] unused_data;
    logic             unused_head;

    for (genvar i = 0; i < DEPTH; i++) begin : g_unused
      assign unused_data[i] = ^entries_i[i].data;
    end
    assign unused_head = ^head_i;
    assign data_o      = '0;
  end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: queues stores, drains them when the memory port is idle, and serves
// loads directly, by forwarding, or by stalling (see STORE_BUFFER_FORWARD_EN in the package).
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned WORD     = SbWord,
  parameter int unsigned ADDRESSL = SbAddressL,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTRW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                storeReq,
  input  logic                loadReq,
  input  logic [ADDRESSL-1:0] reqAddress,
  input  logic [WORD-1:0]     reqWriteData,
  input  logic                flush,
  output logic [WORD-1:0]     loadData,
  output logic                stall,
  output logic                empty,
  store_buffer_if.master      mem
);

  localparam int unsigned CntW = PTRW + 1;

  sb_entry_t        entries_q [DEPTH];
  logic [PTRW-1:0]  head_q, tail_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [DEPTH-1:0] valid;
  sb_entry_t        head_entry;

  logic            match_hit;
  logic [WORD-1:0] match_data;

  logic store_v, full, nonempty;
  logic push, drain;
  logic store_full, flush_stall, load_stall;
  logic load_miss, load_fwd;

  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = CntW'(PTRW'(PTRW'(i) - head_q)) < count_q;
    end
  end

  assign head_entry = entries_q[head_q];

  sb_match #(
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_match (
    .entries_i     (entries_q),
    .valid_i       (valid),
    .head_i        (head_q),
    .req_address_i (reqAddress),
    .hit_o         (match_hit),
    .data_o        (match_data)
  );

  if (!SbForwardEn) begin : g_no_fwd
    logic unused_match_data;
    assign unused_match_data = ^match_data;
  end

  // A load always wins over a simultaneous (illegal) store.
  assign store_v     = storeReq && !loadReq;
  assign nonempty    = count_q != '0;
  assign full        = count_q == CntW'(DEPTH);
  assign flush_stall = flush && nonempty;
  assign store_full  = store_v && full;
  assign load_fwd    = SbForwardEn && loadReq && match_hit;
  assign load_stall  = !SbForwardEn && loadReq && match_hit;
  assign load_miss   = loadReq && !match_hit;
  // A stalled store is replayed by the pipeline, so it must not be pushed now.
  assign push        = store_v && !full && !flush_stall;
  assign drain       = nonempty && !load_miss && !push;
  assign count_d     = count_q + CntW'(push) - CntW'(drain);

  always_comb begin
    loadData         = '0;
    stall            = 1'b0;
    empty            = 1'b1;
    mem.memAddress   = '0;
    mem.memWriteData = '0;
    mem.memRead      = 1'b0;
    mem.memWrite     = 1'b0;
    if (rst) begin
      stall = store_full || flush_stall || load_stall;
      empty = !nonempty;
      if (load_miss) begin
        mem.memRead    = 1'b1;
        mem.memAddress = reqAddress;
        loadData       = mem.memReadData;
      end else if (load_fwd) begin
        loadData = match_data;
      end
      if (drain) begin
        mem.memWrite     = 1'b1;
        mem.memAddress   = head_entry.addr;
        mem.memWriteData = head_entry.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PTRW'(1);
      end
      if (drain) begin
        head_q <= head_q + PTRW'(1);
      end
      count_q <= count_d;
    end
  end

  // Payload needs no reset: only entries covered by count are ever read.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      entries_q[tail_q] <= '{addr: reqAddress, data: reqWriteData};
    end
  end

  a_no_dual_req: assert property (@(posedge clk) disable iff (!rst) !(storeReq && loadReq));

endmodule
